// File: rtl/branch_sequencer.sv
// Multi-cycle PC/IR/flag controller: fetch -> decode -> exec/branch.
// Resolves the conditional branch family and the bl link-register write.
module branch_sequencer #(
   parameter logic [31:0] RESET_PC      = 32'h0,
   parameter int unsigned FETCH_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   input  logic        dec_branch,
   input  logic        dec_branch_src,
   input  logic [4:0]  dec_fcode,
   input  logic        dec_halt,
   input  logic [31:0] label,
   input  logic [31:0] read_data1,
   input  logic        exec_done,
   input  logic        alu_flag_we,
   input  logic        alu_sign,
   input  logic        alu_zero,
   input  logic        alu_carry,
   output logic [31:0] pc,
   output logic        branch_taken,
   output logic        link_we,
   output logic [31:0] link_data,
   output logic [31:0] retire_cnt,
   output logic [2:0]  state,
   output logic        halted,
   output logic        fault
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_BRANCH = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   localparam logic [31:0] TO_LAST = 32'(FETCH_TIMEOUT - 1);

   logic [2:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] ret_q, ret_d;
   logic [31:0] cnt_q, cnt_d;
   logic        fault_q, fault_d;
   logic        s_q, s_d;
   logic        z_q, z_d;
   logic        c_q, c_d;

   logic [31:0] pc_inc;
   logic [31:0] tgt;
   logic        take;

   assign pc_inc = pc_q + 32'd4;
   assign tgt    = dec_branch_src ? read_data1 : label;

   always_comb begin
      case (dec_fcode)
         5'd0:    take = 1'b1;
         5'd1:    take = c_q;
         5'd2:    take = ~c_q;
         5'd3:    take = z_q;
         5'd4:    take = s_q;
         5'd5:    take = ~z_q;
         5'd6:    take = 1'b1;
         default: take = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      ret_d        = ret_q;
      cnt_d        = cnt_q;
      fault_d      = fault_q;
      s_d          = s_q;
      z_d          = z_q;
      c_d          = c_q;
      branch_taken = 1'b0;
      link_we      = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               cnt_d   = '0;
               state_d = S_DECODE;
            end else if (cnt_q >= TO_LAST) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_DECODE: begin
            if (dec_halt)
               state_d = S_HALT;
            else if (dec_branch)
               state_d = S_BRANCH;
            else
               state_d = S_EXEC;
         end
         S_EXEC: begin
            if (exec_done) begin
               pc_d    = pc_inc;
               ret_d   = ret_q + 32'd1;
               state_d = S_FETCH;
               if (alu_flag_we) begin
                  s_d = alu_sign;
                  z_d = alu_zero;
                  c_d = alu_carry;
               end
            end
         end
         S_BRANCH: begin
            // A taken jump to a misaligned target halts without retiring
            if (take && (tgt[1:0] != 2'b00)) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               pc_d         = take ? tgt : pc_inc;
               branch_taken = take;
               link_we      = (dec_fcode == 5'd6);
               ret_d        = ret_q + 32'd1;
               state_d      = S_FETCH;
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         ret_q   <= '0;
         cnt_q   <= '0;
         fault_q <= 1'b0;
         s_q     <= 1'b0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
         s_q     <= s_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
   end

   assign imem_req   = (state_q == S_FETCH);
   assign imem_addr  = pc_q;
   assign ir         = ir_q;
   assign pc         = pc_q;
   assign link_data  = pc_inc;
   assign retire_cnt = ret_q;
   assign state      = state_q;
   assign halted     = (state_q == S_HALT);
   assign fault      = fault_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: table of branch vectors
// plus hand sequences for reset, fault, timeout and wrap cases.
module tb_branch_sequencer;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ir;
   logic        dec_branch;
   logic        dec_branch_src;
   logic [4:0]  dec_fcode;
   logic        dec_halt;
   logic [31:0] label;
   logic [31:0] read_data1;
   logic        exec_done;
   logic        alu_flag_we;
   logic        alu_sign;
   logic        alu_zero;
   logic        alu_carry;
   logic [31:0] pc;
   logic        branch_taken;
   logic        link_we;
   logic [31:0] link_data;
   logic [31:0] retire_cnt;
   logic [2:0]  state;
   logic        halted;
   logic        fault;

   branch_sequencer dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir(ir),
      .dec_branch(dec_branch), .dec_branch_src(dec_branch_src),
      .dec_fcode(dec_fcode), .dec_halt(dec_halt),
      .label(label), .read_data1(read_data1),
      .exec_done(exec_done), .alu_flag_we(alu_flag_we),
      .alu_sign(alu_sign), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .pc(pc), .branch_taken(branch_taken),
      .link_we(link_we), .link_data(link_data),
      .retire_cnt(retire_cnt), .state(state),
      .halted(halted), .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  fcode;
      logic        src;
      logic [31:0] lbl;
      logic [31:0] rd1;
      logic [2:0]  szc;
      logic        exp_take;
      logic        exp_link;
   } vec_t;

   int ncmp;
   int nfail;
   logic [31:0] exp_pc;
   logic [31:0] exp_ret;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_fetch(input int dly, input logic [31:0] w);
      imem_ack = 1'b0;
      for (int i = 0; i < dly; i++) step();
      imem_ack   = 1'b1;
      imem_rdata = w;
      step();
      imem_ack = 1'b0;
      chk("fetch_ir", ir, w);
      chk("fetch_state", 32'(state), 32'd1);
   endtask

   task automatic do_decode(input logic br, input logic hl,
                            input logic src, input logic [4:0] fc,
                            input logic [31:0] lb, input logic [31:0] r1);
      dec_branch     = br;
      dec_halt       = hl;
      dec_branch_src = src;
      dec_fcode      = fc;
      label          = lb;
      read_data1     = r1;
      step();
   endtask

   task automatic do_exec(input int dly, input logic we, input logic [2:0] szc);
      exec_done = 1'b0;
      for (int i = 0; i < dly; i++) step();
      exec_done   = 1'b1;
      alu_flag_we = we;
      alu_sign    = szc[2];
      alu_zero    = szc[1];
      alu_carry   = szc[0];
      step();
      exec_done   = 1'b0;
      alu_flag_we = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_pc  = 32'h0;
      exp_ret = 32'h0;
   endtask

   initial begin
      vec_t vt[13];
      logic [31:0] hold_pc;

      ncmp = 0;
      nfail = 0;
      rst = 1'b1;
      imem_ack = 1'b0;
      imem_rdata = '0;
      dec_branch = 1'b0;
      dec_branch_src = 1'b0;
      dec_fcode = '0;
      dec_halt = 1'b0;
      label = '0;
      read_data1 = '0;
      exec_done = 1'b0;
      alu_flag_we = 1'b0;
      alu_sign = 1'b0;
      alu_zero = 1'b0;
      alu_carry = 1'b0;

      vt[0]  = '{5'd0,  1'b0, 32'd100,     32'h0,   3'b000, 1'b1, 1'b0};
      vt[1]  = '{5'd1,  1'b0, 32'h2710,    32'h0,   3'b001, 1'b1, 1'b0};
      vt[2]  = '{5'd2,  1'b0, 32'h2710,    32'h0,   3'b001, 1'b0, 1'b0};
      vt[3]  = '{5'd9,  1'b0, 32'h2710,    32'h0,   3'b111, 1'b0, 1'b0};
      vt[4]  = '{5'd1,  1'b0, 32'h2710,    32'h0,   3'b110, 1'b0, 1'b0};
      vt[5]  = '{5'd3,  1'b0, 32'h40,      32'h0,   3'b010, 1'b1, 1'b0};
      vt[6]  = '{5'd5,  1'b0, 32'h40,      32'h0,   3'b010, 1'b0, 1'b0};
      vt[7]  = '{5'd5,  1'b0, 32'h80,      32'h0,   3'b101, 1'b1, 1'b0};
      vt[8]  = '{5'd4,  1'b0, 32'h300,     32'h0,   3'b100, 1'b1, 1'b0};
      vt[9]  = '{5'd4,  1'b0, 32'h300,     32'h0,   3'b011, 1'b0, 1'b0};
      vt[10] = '{5'd6,  1'b0, 32'h200,     32'h0,   3'b000, 1'b1, 1'b1};
      vt[11] = '{5'd0,  1'b1, 32'h3,       32'd200, 3'b000, 1'b1, 1'b0};
      vt[12] = '{5'd31, 1'b0, 32'h3,       32'h0,   3'b111, 1'b0, 1'b0};

      // reset held two cycles
      @(negedge clk);
      step();
      rst = 1'b0;
      exp_pc = 32'h0;
      exp_ret = 32'h0;
      chk("rst_pc", pc, 32'h0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd1);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_ir", ir, 32'h0);
      chk("rst_ret", retire_cnt, 32'h0);

      // non-branch with slow ack and slow exec
      do_fetch(3, 32'h1234_5678);
      do_decode(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      chk("nb_state", 32'(state), 32'd2);
      do_exec(2, 1'b1, 3'b001);
      exp_pc = 32'd4;
      exp_ret = 32'd1;
      chk("nb_pc", pc, 32'd4);
      chk("nb_ret", retire_cnt, 32'd1);
      chk("nb_addr", imem_addr, 32'd4);
      chk("nb_req", 32'(imem_req), 32'd1);

      for (int i = 0; i < 13; i++) begin
         do_fetch(1, 32'h0000_1000 + 32'(i));
         do_decode(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
         do_exec(1, 1'b1, vt[i].szc);
         exp_pc = exp_pc + 32'd4;
         exp_ret = exp_ret + 32'd1;
         chk("v_pre_pc", pc, exp_pc);
         do_fetch(0, 32'hB000_0000 + 32'(i));
         do_decode(1'b1, 1'b0, vt[i].src, vt[i].fcode, vt[i].lbl, vt[i].rd1);
         chk("v_state_br", 32'(state), 32'd3);
         chk("v_taken", 32'(branch_taken), 32'(vt[i].exp_take));
         chk("v_link_we", 32'(link_we), 32'(vt[i].exp_link));
         if (vt[i].exp_link)
            chk("v_link_data", link_data, exp_pc + 32'd4);
         step();
         if (vt[i].exp_take)
            exp_pc = vt[i].src ? vt[i].rd1 : vt[i].lbl;
         else
            exp_pc = exp_pc + 32'd4;
         exp_ret = exp_ret + 32'd1;
         chk("v_pc", pc, exp_pc);
         chk("v_ret", retire_cnt, exp_ret);
         chk("v_state_f", 32'(state), 32'd0);
         chk("v_pulse_off", 32'(branch_taken), 32'd0);
         chk("v_link_off", 32'(link_we), 32'd0);
      end

      // misaligned register target faults and halts
      hold_pc = exp_pc;
      do_fetch(0, 32'hC000_0001);
      do_decode(1'b1, 1'b0, 1'b1, 5'd0, 32'h0, 32'd202);
      chk("mis_taken", 32'(branch_taken), 32'd0);
      chk("mis_link", 32'(link_we), 32'd0);
      step();
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_halted", 32'(halted), 32'd1);
      chk("mis_pc", pc, hold_pc);
      chk("mis_ret", retire_cnt, exp_ret);
      repeat (3) step();
      chk("mis_hold_pc", pc, hold_pc);
      chk("mis_hold_req", 32'(imem_req), 32'd0);
      chk("mis_hold_state", 32'(state), 32'd4);

      // halt wins over branch in decode
      do_reset();
      chk("rst2_fault", 32'(fault), 32'd0);
      chk("rst2_state", 32'(state), 32'd0);
      do_fetch(0, 32'hD000_0000);
      do_decode(1'b1, 1'b1, 1'b0, 5'd0, 32'h100, 32'h0);
      chk("hlt_state", 32'(state), 32'd4);
      chk("hlt_halted", 32'(halted), 32'd1);
      chk("hlt_fault", 32'(fault), 32'd0);
      step();
      chk("hlt_pc", pc, 32'h0);
      chk("hlt_ret", retire_cnt, 32'h0);

      // fetch timeout: 254 idle cycles still fetching, 255th faults
      do_reset();
      dec_halt = 1'b0;
      imem_ack = 1'b0;
      repeat (254) step();
      chk("to_before_state", 32'(state), 32'd0);
      chk("to_before_fault", 32'(fault), 32'd0);
      step();
      chk("to_fault", 32'(fault), 32'd1);
      chk("to_state", 32'(state), 32'd4);
      chk("to_req", 32'(imem_req), 32'd0);

      // reset arriving mid-fetch with an ack pending
      do_reset();
      do_fetch(0, 32'hE000_0000);
      do_decode(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      do_exec(0, 1'b0, 3'b000);
      chk("mf_pc", pc, 32'd4);
      chk("mf_ir", ir, 32'hE000_0000);
      rst = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'hF00D_F00D;
      step();
      rst = 1'b0;
      imem_ack = 1'b0;
      chk("mf_rst_pc", pc, 32'h0);
      chk("mf_rst_ir", ir, 32'h0);
      chk("mf_rst_state", 32'(state), 32'd0);
      chk("mf_rst_ret", retire_cnt, 32'h0);

      // pc wraps from FFFFFFFC to 0
      do_fetch(0, 32'hA000_0000);
      do_decode(1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFC, 32'h0);
      step();
      chk("wr_pc_top", pc, 32'hFFFF_FFFC);
      do_fetch(0, 32'hA000_0001);
      do_decode(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      do_exec(0, 1'b0, 3'b000);
      chk("wr_pc", pc, 32'h0);
      chk("wr_ret", retire_cnt, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
